riscv_wb_checker: RTL and testbench
===================================

# riscv_wb_checker

Synthesizable, parametrised write-back stream checker for the RISC_V pipeline, the successor to our free-running processor bench. Driven alongside the core, it:

- queues expected write-back values;
- compares them in order against the observed `ALU_DATA_WB` stream;
- counts forwarding (`forwardA`/`forwardB`) and stall (`control_sel`) activity;
- flags PASS, FAIL or TIMEOUT through a small state machine.

It replaces fixed-time `$finish` runs with a self-checking verdict usable in simulation and on an FPGA.

## Interface
- `DATA_W`, 32, width of expected/observed data
- `DEPTH`, 16, expected-value FIFO depth; power of 2, ≥2
- `CNT_W`, 16, width of all event counters
- `TIMEOUT`, 64, max consecutive cycles without an observation while expectations are pending
- `FWD_W`, 2, width of the forward-select inputs
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-low
- `start`  in  1  pulse: clear counters, FIFO and first-error capture; enter RUN
- `done`  in  1  stimulus finished; request verdict
- `exp_valid`  in  1  expected value offered
- `exp_data`  in  DATA_W  expected write-back value
- `exp_ready`  out  1  FIFO can accept (= !full)
- `obs_valid`  in  1  core retired a write-back this cycle
- `obs_data`  in  DATA_W  observed `ALU_DATA_WB`
- `forwardA`, `forwardB`  in  FWD_W each  core forward selects
- `control_sel`  in  1  core hazard/stall select
- `state`  out  3  IDLE=0, RUN=1, PASS=2, FAIL=3, TIMEOUT=4
- `pass`, `fail`  out  1 each  `pass` = state==PASS; `fail` = state is FAIL or TIMEOUT
- `match_cnt`, `mismatch_cnt`  out  CNT_W each  comparison results
- `fwd_a_cnt`, `fwd_b_cnt`, `stall_cnt`  out  CNT_W each  cycles in RUN with `forwardA`≠0 / `forwardB`≠0 / `control_sel`=1
- `bad_idx`  out  CNT_W  observation index of the first mismatch
- `bad_exp`, `bad_obs`  out  DATA_W each  expected and observed values at the first mismatch

## Operation
- Reset (`reset`=0): state IDLE, FIFO empty, all counters and `bad_*` outputs 0, `pass`/`fail` 0, `exp_ready` 1.
- IDLE → RUN on `start`. `start` in any state clears everything and enters RUN.
- **FIFO**
  - Push when `exp_valid & exp_ready`.
  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH; full/empty are distinguished by an extra wrap bit.
- **Observation** (`obs_valid` in RUN, FAIL or TIMEOUT)
  - FIFO non-empty: pop the head and compare. Equal increments `match_cnt`; unequal increments `mismatch_cnt`.
  - FIFO empty: the observation is unexpected and counts as a mismatch; `bad_exp` = 0.
- First mismatch latches `bad_idx` (0-based count of observations since `start`), `bad_exp` and `bad_obs`. Later mismatches do not overwrite them.
- **State transitions**
  - RUN → FAIL on any mismatch.
  - RUN → TIMEOUT when the FIFO is non-empty and `obs_valid` has been low for TIMEOUT consecutive cycles.
  - RUN → PASS on `done` if the FIFO is empty and `mismatch_cnt`=0; otherwise RUN → FAIL.
  - PASS, FAIL and TIMEOUT are terminal until `start` or reset.
- Counting: match/mismatch counting continues in FAIL/TIMEOUT; fwd/stall counters count only in RUN.
- All counters saturate at 2^CNT_W−1.
- Observations and pushes in IDLE or PASS are ignored.

## Timing
- Comparison is combinational on the FIFO head in the `obs_valid` cycle. Counters, `bad_*` and `state` update at the next rising edge.
- `exp_ready` derives from the registered full flag only. When full, a push is refused even if a pop occurs in the same cycle.
- When empty, an `obs_valid` arriving in the same cycle as a push is unexpected (mismatch); the pushed value is still stored.
- Mismatch and `done` in the same cycle → FAIL. Mismatch and timeout expiry in the same cycle → FAIL.
- The timeout counter resets on any `obs_valid` and whenever the FIFO is empty.
- `start` has priority over every other event.
- Asserting `reset` mid-run returns all outputs to their reset values immediately, without waiting for a clock edge.

## Structure
- Package `riscv_tb_pkg`: state enum (IDLE..TIMEOUT), default parameter constants, saturating-increment function.
- Sub-module `riscv_exp_fifo`: parametrised synchronous FIFO (DATA_W, DEPTH) with push/pop, full/empty and async active-low reset.
- The top level holds the FSM, counters, watchdog and first-error capture.

## Test plan
1. Push 0x5, 0xA, 0xF; observe 0x5, 0xA, 0xF; then `done` → PASS, `match_cnt`=3, `mismatch_cnt`=0.
2. Push 0x10, 0x20; observe 0x10, 0x21 → FAIL one cycle later, `bad_idx`=1, `bad_exp`=0x20, `bad_obs`=0x21.
3. Push DEPTH values with no observations → `exp_ready`=0 after the DEPTH-th push. The (DEPTH+1)-th push is refused. Then observe all DEPTH values with wrap-around → PASS on `done`.
4. Push 1 value, hold `obs_valid`=0 → TIMEOUT exactly TIMEOUT cycles after the last observation/push-to-nonempty; `fail`=1.
5. Drive `forwardA`=2 for 3 cycles, `forwardB`=1 for 2 cycles, `control_sel`=1 for 1 cycle in RUN → `fwd_a_cnt`=3, `fwd_b_cnt`=2, `stall_cnt`=1.
6. `obs_valid` with FIFO empty → FAIL with `bad_exp`=0. Assert `reset`=0 mid-run → all outputs at reset values immediately.

Source files
------------

// File: rtl/riscv_tb_pkg.sv
// Shared types and helpers for the RISC-V write-back stream checker.
// Holds the verdict state encoding, default parameters and a saturating increment.
package riscv_tb_pkg;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StRun     = 3'd1,
    StPass    = 3'd2,
    StFail    = 3'd3,
    StTimeout = 3'd4
  } state_e;

  localparam int unsigned DefDataW   = 32;
  localparam int unsigned DefDepth   = 16;
  localparam int unsigned DefCntW    = 16;
  localparam int unsigned DefTimeout = 64;
  localparam int unsigned DefFwdW    = 2;

  // Widest counter the helper supports; narrower counters are zero-extended into it.
  localparam int unsigned MaxCntW = 32;

  // Increment v, holding at 2^w-1 for a w-bit counter.
  function automatic logic [MaxCntW-1:0] sat_inc(input logic [MaxCntW-1:0] v,
                                                 input int unsigned         w);
    logic [MaxCntW-1:0] top;
    top = (w >= MaxCntW) ? '1 : ((MaxCntW'(1) << w) - MaxCntW'(1));
    return (v >= top) ? top : v + MaxCntW'(1);
  endfunction

endpackage

// File: rtl/riscv_wb_checker_if.sv
// Stimulus/handshake bundle between the pipeline harness and the write-back checker.
interface riscv_wb_checker_if
  import riscv_tb_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned FWD_W  = DefFwdW
) ();

  logic              start;
  logic              done;
  logic              exp_valid;
  logic [DATA_W-1:0] exp_data;
  logic              exp_ready;
  logic              obs_valid;
  logic [DATA_W-1:0] obs_data;
  logic [FWD_W-1:0]  forwardA;
  logic [FWD_W-1:0]  forwardB;
  logic              control_sel;

  modport master (
    output start, done, exp_valid, exp_data, obs_valid, obs_data,
    output forwardA, forwardB, control_sel,
    input  exp_ready
  );

  modport slave (
    input  start, done, exp_valid, exp_data, obs_valid, obs_data,
    input  forwardA, forwardB, control_sel,
    output exp_ready
  );

endinterface

// File: rtl/riscv_exp_fifo.sv
// Synchronous FIFO of expected write-back values with a flush input.
// Pointers carry one extra wrap bit to tell full from empty.
module riscv_exp_fifo #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] data_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic              do_push, do_pop;

  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  // Full is judged before any same-cycle pop, so a push into a full FIFO is always refused.
  assign do_push = push_i & ~full_o & ~clr_i;
  assign do_pop  = pop_i & ~empty_o & ~clr_i;
  assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/riscv_wb_checker.sv
// In-order write-back checker: compares observed ALU_DATA_WB against queued expectations,
// counts forwarding/stall activity and reports a PASS/FAIL/TIMEOUT verdict.
module riscv_wb_checker
  import riscv_tb_pkg::*;
#(
  parameter int unsigned DATA_W  = DefDataW,
  parameter int unsigned DEPTH   = DefDepth,
  parameter int unsigned CNT_W   = DefCntW,
  parameter int unsigned TIMEOUT = DefTimeout,
  parameter int unsigned FWD_W   = DefFwdW
) (
  input  logic              clk,
  input  logic              reset,
  riscv_wb_checker_if.slave bus,
  output logic [2:0]        state,
  output logic              pass,
  output logic              fail,
  output logic [CNT_W-1:0]  match_cnt,
  output logic [CNT_W-1:0]  mismatch_cnt,
  output logic [CNT_W-1:0]  fwd_a_cnt,
  output logic [CNT_W-1:0]  fwd_b_cnt,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bad_idx,
  output logic [DATA_W-1:0] bad_exp,
  output logic [DATA_W-1:0] bad_obs
);

  localparam int unsigned WdW = $clog2(TIMEOUT + 1);

  function automatic logic [CNT_W-1:0] inc(input logic [CNT_W-1:0] v);
    return CNT_W'(sat_inc(MaxCntW'(v), CNT_W));
  endfunction

  state_e            state_q, state_d;
  logic [WdW-1:0]    wd_q, wd_d;
  logic [CNT_W-1:0]  obs_cnt_q, obs_cnt_d;
  logic [CNT_W-1:0]  match_q, match_d, mis_q, mis_d;
  logic [CNT_W-1:0]  fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d, stall_q, stall_d;
  logic [CNT_W-1:0]  bad_idx_q, bad_idx_d;
  logic [DATA_W-1:0] bad_exp_q, bad_exp_d, bad_obs_q, bad_obs_d;

  logic              fifo_full, fifo_empty;
  logic [DATA_W-1:0] fifo_head;
  logic [FWD_W-1:0]  fwd_a, fwd_b;
  logic              active, in_run, obs_act, push, pop, is_match, is_mis, wd_expire;

  assign fwd_a = bus.forwardA;
  assign fwd_b = bus.forwardB;

  // Observations and pushes are honoured in RUN and in the failing terminal states.
  assign active   = (state_q == StRun) || (state_q == StFail) || (state_q == StTimeout);
  assign in_run   = (state_q == StRun);
  assign obs_act  = bus.obs_valid & active & ~bus.start;
  assign push     = bus.exp_valid & active & ~bus.start;
  assign pop      = obs_act & ~fifo_empty;
  assign is_match = pop & (fifo_head == bus.obs_data);
  assign is_mis   = obs_act & ~is_match;

  riscv_exp_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (reset),
    .clr_i   (bus.start),
    .push_i  (push),
    .data_i  (bus.exp_data),
    .pop_i   (pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Watchdog: consecutive RUN cycles with pending expectations and no observation.
  always_comb begin
    wd_d      = '0;
    wd_expire = 1'b0;
    if (in_run && !bus.start && !bus.obs_valid && !fifo_empty) begin
      wd_d      = wd_q + WdW'(1);
      wd_expire = (wd_q == WdW'(TIMEOUT - 1));
    end
  end

  always_comb begin
    state_d = state_q;
    if (bus.start) begin
      state_d = StRun;
    end else if (in_run) begin
      if (is_mis) begin
        state_d = StFail;
      end else if (bus.done) begin
        state_d = (fifo_empty && (mis_q == '0)) ? StPass : StFail;
      end else if (wd_expire) begin
        state_d = StTimeout;
      end
    end
  end

  always_comb begin
    obs_cnt_d = obs_cnt_q;
    match_d   = match_q;
    mis_d     = mis_q;
    fwd_a_d   = fwd_a_q;
    fwd_b_d   = fwd_b_q;
    stall_d   = stall_q;
    bad_idx_d = bad_idx_q;
    bad_exp_d = bad_exp_q;
    bad_obs_d = bad_obs_q;
    if (bus.start) begin
      obs_cnt_d = '0;
      match_d   = '0;
      mis_d     = '0;
      fwd_a_d   = '0;
      fwd_b_d   = '0;
      stall_d   = '0;
      bad_idx_d = '0;
      bad_exp_d = '0;
      bad_obs_d = '0;
    end else begin
      if (obs_act)  obs_cnt_d = inc(obs_cnt_q);
      if (is_match) match_d   = inc(match_q);
      if (is_mis) begin
        mis_d = inc(mis_q);
        // A saturated mismatch count never returns to zero, so zero marks "no capture yet".
        if (mis_q == '0) begin
          bad_idx_d = obs_cnt_q;
          bad_exp_d = pop ? fifo_head : '0;
          bad_obs_d = bus.obs_data;
        end
      end
      if (in_run) begin
        if (|fwd_a)          fwd_a_d = inc(fwd_a_q);
        if (|fwd_b)          fwd_b_d = inc(fwd_b_q);
        if (bus.control_sel) stall_d = inc(stall_q);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wd_q      <= '0;
      obs_cnt_q <= '0;
      match_q   <= '0;
      mis_q     <= '0;
      fwd_a_q   <= '0;
      fwd_b_q   <= '0;
      stall_q   <= '0;
      bad_idx_q <= '0;
      bad_exp_q <= '0;
      bad_obs_q <= '0;
    end else begin
      wd_q      <= wd_d;
      obs_cnt_q <= obs_cnt_d;
      match_q   <= match_d;
      mis_q     <= mis_d;
      fwd_a_q   <= fwd_a_d;
      fwd_b_q   <= fwd_b_d;
      stall_q   <= stall_d;
      bad_idx_q <= bad_idx_d;
      bad_exp_q <= bad_exp_d;
      bad_obs_q <= bad_obs_d;
    end
  end

  assign bus.exp_ready = ~fifo_full;
  assign state         = state_q;
  assign pass          = (state_q == StPass);
  assign fail          = (state_q == StFail) || (state_q == StTimeout);
  assign match_cnt     = match_q;
  assign mismatch_cnt  = mis_q;
  assign fwd_a_cnt     = fwd_a_q;
  assign fwd_b_cnt     = fwd_b_q;
  assign stall_cnt     = stall_q;
  assign bad_idx       = bad_idx_q;
  assign bad_exp       = bad_exp_q;
  assign bad_obs       = bad_obs_q;

endmodule

// File: tb/tb_riscv_wb_checker.sv
// Directed bench for riscv_wb_checker: a queue-based reference model checked every
// negative edge, plus hand-computed expectations for each scenario.
module tb_riscv_wb_checker;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = 16;
  localparam int unsigned TO    = 8;
  localparam int unsigned FW    = 2;
  localparam longint      CMAX  = (64'd1 << CW) - 1;

  logic          clk;
  logic          reset;
  logic [2:0]    state;
  logic          pass, fail;
  logic [CW-1:0] match_cnt, mismatch_cnt, fwd_a_cnt, fwd_b_cnt, stall_cnt, bad_idx;
  logic [DW-1:0] bad_exp, bad_obs;

  riscv_wb_checker_if #(.DATA_W(DW), .FWD_W(FW)) bus ();

  riscv_wb_checker #(
    .DATA_W  (DW),
    .DEPTH   (DEPTH),
    .CNT_W   (CW),
    .TIMEOUT (TO),
    .FWD_W   (FW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .state        (state),
    .pass         (pass),
    .fail         (fail),
    .match_cnt    (match_cnt),
    .mismatch_cnt (mismatch_cnt),
    .fwd_a_cnt    (fwd_a_cnt),
    .fwd_b_cnt    (fwd_b_cnt),
    .stall_cnt    (stall_cnt),
    .bad_idx      (bad_idx),
    .bad_exp      (bad_exp),
    .bad_obs      (bad_obs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  bit cmp_on = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
  endtask

  // ---------------- reference model (state numbering: 0 idle .. 4 timeout) ----------------
  logic [DW-1:0] q[$];
  int            m_state = 0;
  int            m_idle  = 0;
  longint        m_match = 0, m_mis = 0, m_fa = 0, m_fb = 0, m_st = 0, m_nobs = 0, m_bidx = 0;
  logic [DW-1:0] m_bexp  = '0, m_bobs = '0;

  function automatic longint sat(input longint v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  task automatic m_clear();
    q.delete();
    m_idle = 0; m_match = 0; m_mis = 0; m_fa = 0; m_fb = 0; m_st = 0;
    m_nobs = 0; m_bidx = 0; m_bexp = '0; m_bobs = '0;
  endtask

  task automatic m_step();
    int            sz0;
    bit            act, mis_now;
    logic [DW-1:0] e;
    sz0     = q.size();
    mis_now = 1'b0;
    if (bus.start) begin
      m_clear();
      m_state = 1;
      return;
    end
    act = (m_state == 1) || (m_state == 3) || (m_state == 4);
    if (act && bus.obs_valid) begin
      e = '0;
      if (sz0 > 0) e = q.pop_front();
      if (sz0 > 0 && e == bus.obs_data) begin
        m_match = sat(m_match);
      end else begin
        if (m_mis == 0) begin
          m_bidx = m_nobs; m_bexp = e; m_bobs = bus.obs_data;
        end
        m_mis   = sat(m_mis);
        mis_now = 1'b1;
      end
      m_nobs = sat(m_nobs);
    end
    if (act && bus.exp_valid && sz0 < int'(DEPTH)) q.push_back(bus.exp_data);
    if (m_state == 1) begin
      if (bus.forwardA != 0) m_fa = sat(m_fa);
      if (bus.forwardB != 0) m_fb = sat(m_fb);
      if (bus.control_sel)   m_st = sat(m_st);
      if (bus.obs_valid || sz0 == 0) m_idle = 0;
      else m_idle++;
      if (mis_now)       m_state = 3;
      else if (bus.done) m_state = (sz0 == 0 && m_mis == 0) ? 2 : 3;
      else if (m_idle >= int'(TO)) m_state = 4;
    end
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_clear();
      m_state = 0;
    end else begin
      m_step();
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("state",     64'(state),        64'(m_state));
      chk("pass",      64'(pass),         64'(m_state == 2));
      chk("fail",      64'(fail),         64'(m_state == 3 || m_state == 4));
      chk("exp_ready", 64'(bus.exp_ready), 64'(q.size() != int'(DEPTH)));
      chk("match",     64'(match_cnt),    64'(m_match));
      chk("mismatch",  64'(mismatch_cnt), 64'(m_mis));
      chk("fwd_a",     64'(fwd_a_cnt),    64'(m_fa));
      chk("fwd_b",     64'(fwd_b_cnt),    64'(m_fb));
      chk("stall",     64'(stall_cnt),    64'(m_st));
      chk("bad_idx",   64'(bad_idx),      64'(m_bidx));
      chk("bad_exp",   64'(bad_exp),      64'(m_bexp));
      chk("bad_obs",   64'(bad_obs),      64'(m_bobs));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    bus.start = 1'b0; bus.done = 1'b0; bus.exp_valid = 1'b0; bus.exp_data = '0;
    bus.obs_valid = 1'b0; bus.obs_data = '0; bus.forwardA = '0; bus.forwardB = '0;
    bus.control_sel = 1'b0;
  endtask

  task automatic do_start();
    bus.start = 1'b1; tick(); bus.start = 1'b0;
  endtask

  task automatic do_done();
    bus.done = 1'b1; tick(); bus.done = 1'b0;
  endtask

  task automatic push(input logic [DW-1:0] d);
    bus.exp_valid = 1'b1; bus.exp_data = d; tick(); bus.exp_valid = 1'b0;
  endtask

  task automatic obs(input logic [DW-1:0] d);
    bus.obs_valid = 1'b1; bus.obs_data = d; tick(); bus.obs_valid = 1'b0;
  endtask

  int got;

  initial begin
    clr_in();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", 64'(state), 64'd0);
    chk("rst_ready", 64'(bus.exp_ready), 64'd1);
    chk("rst_pf",    64'({pass, fail}), 64'd0);
    reset  = 1'b1;
    cmp_on = 1'b1;
    tick();

    // Activity in IDLE is ignored.
    obs(32'h99);
    push(32'h98);
    chk("idle_mis", 64'(mismatch_cnt), 64'd0);

    // 1: clean in-order stream.
    do_start();
    push(32'h5); push(32'hA); push(32'hF);
    obs(32'h5);  obs(32'hA);  obs(32'hF);
    do_done();
    chk("t1_state", 64'(state), 64'd2);
    chk("t1_pass",  64'(pass), 64'd1);
    chk("t1_match", 64'(match_cnt), 64'd3);
    chk("t1_mis",   64'(mismatch_cnt), 64'd0);
    obs(32'h1234);
    chk("t1_pass_ignore", 64'(mismatch_cnt), 64'd0);

    // 2: second value wrong.
    do_start();
    push(32'h10); push(32'h20);
    obs(32'h10);
    chk("t2_run", 64'(state), 64'd1);
    obs(32'h21);
    chk("t2_state",   64'(state), 64'd3);
    chk("t2_bad_idx", 64'(bad_idx), 64'd1);
    chk("t2_bad_exp", 64'(bad_exp), 64'h20);
    chk("t2_bad_obs", 64'(bad_obs), 64'h21);
    obs(32'h77);
    chk("t2_keep_obs", 64'(bad_obs), 64'h21);

    // 3: fill, refused pushes, wrap-around.
    do_start();
    for (int i = 0; i < int'(DEPTH); i++) push(32'h100 + i);
    chk("t3_full", 64'(bus.exp_ready), 64'd0);
    push(32'hDEAD);
    bus.exp_valid = 1'b1; bus.exp_data = 32'hBEEF;
    obs(32'h100);
    bus.exp_valid = 1'b0;
    chk("t3_ready", 64'(bus.exp_ready), 64'd1);
    obs(32'h101);
    push(32'h200); push(32'h201);
    obs(32'h102); obs(32'h103); obs(32'h200); obs(32'h201);
    do_done();
    chk("t3_pass",  64'(pass), 64'd1);
    chk("t3_match", 64'(match_cnt), 64'(DEPTH + 2));

    // 4: watchdog.
    do_start();
    push(32'h77);
    got = -1;
    for (int n = 1; n <= 3 * int'(TO); n++) begin
      tick();
      if (state == 3'd4) begin
        got = n;
        break;
      end
    end
    chk("t4_cycles", 64'(got), 64'(TO));
    chk("t4_fail",   64'(fail), 64'd1);
    obs(32'h77);
    chk("t4_match_in_timeout", 64'(match_cnt), 64'd1);
    chk("t4_still_timeout",    64'(state), 64'd4);

    // 5: forwarding and stall counters.
    do_start();
    bus.forwardA = 2'd2; bus.forwardB = 2'd1; bus.control_sel = 1'b1; tick();
    bus.control_sel = 1'b0; tick();
    bus.forwardB = 2'd0; tick();
    clr_in(); tick();
    chk("t5_fa", 64'(fwd_a_cnt), 64'd3);
    chk("t5_fb", 64'(fwd_b_cnt), 64'd2);
    chk("t5_st", 64'(stall_cnt), 64'd1);

    // done with pending expectations, and mismatch coinciding with done.
    do_start();
    push(32'h3);
    do_done();
    chk("done_pending", 64'(state), 64'd3);
    do_start();
    push(32'h1);
    bus.obs_valid = 1'b1; bus.obs_data = 32'h2; bus.done = 1'b1; tick();
    clr_in();
    chk("mis_and_done", 64'(state), 64'd3);

    // 6: unexpected observation, then asynchronous reset mid-cycle.
    do_start();
    bus.exp_valid = 1'b1; bus.exp_data = 32'h66;
    obs(32'h55);
    bus.exp_valid = 1'b0;
    chk("t6_state",   64'(state), 64'd3);
    chk("t6_bad_exp", 64'(bad_exp), 64'd0);
    chk("t6_bad_obs", 64'(bad_obs), 64'h55);
    obs(32'h66);
    chk("t6_stored",  64'(match_cnt), 64'd1);
    #2 reset = 1'b0;
    #1;
    chk("t6_rst_state", 64'(state), 64'd0);
    chk("t6_rst_fail",  64'(fail), 64'd0);
    chk("t6_rst_cnt",   64'({match_cnt, mismatch_cnt}), 64'd0);
    chk("t6_rst_bad",   64'({bad_idx, bad_obs}), 64'd0);
    chk("t6_rst_ready", 64'(bus.exp_ready), 64'd1);
    #4 reset = 1'b1;
    tick();

    do_start();
    push(32'h42);
    obs(32'h42);
    do_done();
    chk("post_rst_pass", 64'(pass), 64'd1);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
